// File: rtl/kernel_sram_pkg.sv
// Shared types and constants for the kernel-weight SRAM loader.
// The read-latency check is used at elaboration by the top level.
package kernel_sram_pkg;

    localparam int unsigned KS_WORDS = 1152;
    localparam int unsigned KS_WIDTH = 73;
    localparam int unsigned KS_AW    = $clog2(KS_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } ks_state_e;

    function automatic bit rd_lat_legal(input int unsigned lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/kernel_sram_loader_if.sv
// Load-stream and read-port signals of the kernel-weight buffer.
// master = host/conv engine side, slave = buffer side.
interface kernel_sram_loader_if
    import kernel_sram_pkg::*;
#(
    parameter int unsigned WIDTH = KS_WIDTH,
    parameter int unsigned AW    = KS_AW
);

    logic             ld_start;
    logic             ld_valid;
    logic             ld_ready;
    logic [WIDTH-1:0] ld_data;
    logic             ld_last;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;

    modport master (
        output ld_start, ld_valid, ld_data, ld_last, rd_en, rd_addr,
        input  ld_ready, rd_data, rd_valid
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, rd_en, rd_addr,
        output ld_ready, rd_data, rd_valid
    );

endinterface

// File: rtl/sram_2p_core.sv
// Simple-dual-port memory: one synchronous write and one synchronous read per cycle.
// The array itself is never reset; only the read register is.
module sram_2p_core #(
    parameter int unsigned WORDS    = 1152,
    parameter int unsigned WIDTH    = 73,
    parameter int unsigned RDW_MODE = 0,
    localparam int unsigned AW      = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam bit BYPASS = (RDW_MODE != 0);

    logic [WIDTH-1:0] mem [WORDS];
    logic             in_range;
    logic             collide;

    assign in_range = {1'b0, raddr} < (AW+1)'(WORDS);
    assign collide  = we && (waddr == raddr);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Out-of-range reads return zero so the output never carries X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            if (BYPASS && collide) begin
                rdata <= wdata;
            end else if (in_range) begin
                rdata <= mem[raddr];
            end else begin
                rdata <= '0;
            end
        end
    end

endmodule

// File: rtl/kernel_sram_loader.sv
// Kernel-weight buffer: streaming load FSM with auto-incrementing write pointer,
// random-access read port with 1- or 2-cycle latency.
module kernel_sram_loader
    import kernel_sram_pkg::*;
#(
    parameter int unsigned WORDS    = KS_WORDS,
    parameter int unsigned WIDTH    = KS_WIDTH,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned RDW_MODE = 0,
    localparam int unsigned AW      = $clog2(WORDS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    kernel_sram_loader_if.slave  bus,
    output logic                 loaded,
    output logic [AW:0]          ld_count,
    output logic                 ovf_err
);

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_lat
        $error("kernel_sram_loader: RD_LAT must be 1 or 2");
    end

    ks_state_e        state_q;
    ks_state_e        state_d;
    logic [AW-1:0]    wptr_q;
    logic             accept;
    logic             last_slot;
    logic             rd_v1_q;
    logic [WIDTH-1:0] core_rdata;

    assign bus.ld_ready = (state_q == LOAD) && !bus.ld_start;
    assign accept       = bus.ld_valid && bus.ld_ready;
    assign last_slot    = (wptr_q == AW'(WORDS - 1));

    // Next-state: ld_start always (re)enters LOAD; a final or buffer-filling word ends it.
    always_comb begin
        state_d = state_q;
        if (bus.ld_start) begin
            state_d = LOAD;
        end else if ((state_q == LOAD) && accept && (bus.ld_last || last_slot)) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write pointer and load status; loaded follows DONE by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            ld_count <= '0;
            loaded   <= 1'b0;
            ovf_err  <= 1'b0;
        end else if (bus.ld_start) begin
            wptr_q   <= '0;
            ld_count <= '0;
            loaded   <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            if (accept) begin
                wptr_q   <= wptr_q + AW'(1);
                ld_count <= ld_count + (AW+1)'(1);
            end
            if (state_q == DONE) begin
                loaded <= 1'b1;
                if (bus.ld_valid) begin
                    ovf_err <= 1'b1;
                end
            end
        end
    end

    sram_2p_core #(
        .WORDS    (WORDS),
        .WIDTH    (WIDTH),
        .RDW_MODE (RDW_MODE)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .waddr (wptr_q),
        .wdata (bus.ld_data),
        .re    (bus.rd_en),
        .raddr (bus.rd_addr),
        .rdata (core_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1_q <= 1'b0;
        end else begin
            rd_v1_q <= bus.rd_en;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic             rd_v2_q;
        logic [WIDTH-1:0] rd_d2_q;

        // Extra output stage; holds its value between valid reads.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_v2_q <= 1'b0;
                rd_d2_q <= '0;
            end else begin
                rd_v2_q <= rd_v1_q;
                if (rd_v1_q) begin
                    rd_d2_q <= core_rdata;
                end
            end
        end

        assign bus.rd_valid = rd_v2_q;
        assign bus.rd_data  = rd_d2_q;
    end else begin : g_lat1
        assign bus.rd_valid = rd_v1_q;
        assign bus.rd_data  = core_rdata;
    end

endmodule

// File: tb/tb_kernel_sram_loader.sv
// Scoreboard bench: two loaders (RD_LAT=1/RDW_MODE=0 and RD_LAT=2/RDW_MODE=1) share one stimulus
// stream and are compared against an array-based model of the load and read rules.
module tb_kernel_sram_loader;
    import kernel_sram_pkg::*;

    localparam int unsigned WORDS = KS_WORDS;
    localparam int unsigned WIDTH = KS_WIDTH;
    localparam int unsigned AW    = KS_AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic             ld_start = 1'b0;
    logic             ld_valid = 1'b0;
    logic             ld_last  = 1'b0;
    logic             rd_en    = 1'b0;
    logic [WIDTH-1:0] ld_data  = '0;
    logic [AW-1:0]    rd_addr  = '0;

    kernel_sram_loader_if #(.WIDTH(WIDTH), .AW(AW)) bus_a ();
    kernel_sram_loader_if #(.WIDTH(WIDTH), .AW(AW)) bus_b ();

    assign bus_a.ld_start = ld_start;
    assign bus_a.ld_valid = ld_valid;
    assign bus_a.ld_data  = ld_data;
    assign bus_a.ld_last  = ld_last;
    assign bus_a.rd_en    = rd_en;
    assign bus_a.rd_addr  = rd_addr;
    assign bus_b.ld_start = ld_start;
    assign bus_b.ld_valid = ld_valid;
    assign bus_b.ld_data  = ld_data;
    assign bus_b.ld_last  = ld_last;
    assign bus_b.rd_en    = rd_en;
    assign bus_b.rd_addr  = rd_addr;

    logic          loaded_a, ovf_a, loaded_b, ovf_b;
    logic [AW:0]   cnt_a, cnt_b;

    kernel_sram_loader #(.RD_LAT(1), .RDW_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a),
        .loaded(loaded_a), .ld_count(cnt_a), .ovf_err(ovf_a)
    );

    kernel_sram_loader #(.RD_LAT(2), .RDW_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b),
        .loaded(loaded_b), .ld_count(cnt_b), .ovf_err(ovf_b)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        bit               chk;
        longint           due;
    } exp_t;

    exp_t   q [2][$];
    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;

    // Model of the buffer: contents, which words were ever written, and load status.
    logic [WIDTH-1:0] m_mem [WORDS];
    bit               m_wr  [WORDS];
    bit               m_loading = 0;
    bit               m_done    = 0;
    bit               m_loaded  = 0;
    bit               m_ovf     = 0;
    int               m_cnt     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return WIDTH'(r);
    endfunction

    // One cycle of stimulus: called at posedge+1, returns at the following posedge+1.
    task automatic drive(input bit st, input bit v, input logic [WIDTH-1:0] d,
                         input bit last, input bit re, input int ra);
        bit   acc;
        exp_t ea, eb;
        ld_start = st; ld_valid = v; ld_data = d; ld_last = last;
        rd_en = re; rd_addr = AW'(ra);
        #1;
        check("ld_ready_a", 128'(bus_a.ld_ready), 128'(m_loading && !st));
        check("ld_ready_b", 128'(bus_b.ld_ready), 128'(m_loading && !st));
        acc = m_loading && !st && v;
        if (re) begin
            ea.data = m_mem[ra];
            ea.chk  = m_wr[ra];
            ea.due  = cyc + 1;
            eb.data = (acc && ra == m_cnt) ? d : m_mem[ra];
            eb.chk  = m_wr[ra] || (acc && ra == m_cnt);
            eb.due  = cyc + 2;
            q[0].push_back(ea);
            q[1].push_back(eb);
        end
        if (st) begin
            m_loading = 1; m_done = 0; m_cnt = 0; m_loaded = 0; m_ovf = 0;
        end else begin
            if (m_done) begin
                m_loaded = 1;
                if (v) m_ovf = 1;
            end
            if (acc) begin
                m_mem[m_cnt] = d;
                m_wr[m_cnt]  = 1;
                m_cnt++;
                if (last || m_cnt == WORDS) begin
                    m_loading = 0;
                    m_done    = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("ld_count_a", 128'(cnt_a), 128'(m_cnt));
        check("ld_count_b", 128'(cnt_b), 128'(m_cnt));
        check("loaded_a", 128'(loaded_a), 128'(m_loaded));
        check("loaded_b", 128'(loaded_b), 128'(m_loaded));
        check("ovf_err_a", 128'(ovf_a), 128'(m_ovf));
        check("ovf_err_b", 128'(ovf_b), 128'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count_a"}, 128'(cnt_a), 128'(0));
        check({tag, "_count_b"}, 128'(cnt_b), 128'(0));
        check({tag, "_loaded_a"}, 128'(loaded_a), 128'(0));
        check({tag, "_loaded_b"}, 128'(loaded_b), 128'(0));
        check({tag, "_ovf_a"}, 128'(ovf_a), 128'(0));
        check({tag, "_ovf_b"}, 128'(ovf_b), 128'(0));
        check({tag, "_rvalid_a"}, 128'(bus_a.rd_valid), 128'(0));
        check({tag, "_rvalid_b"}, 128'(bus_b.rd_valid), 128'(0));
        check({tag, "_rdata_a"}, 128'(bus_a.rd_data), 128'(0));
        check({tag, "_rdata_b"}, 128'(bus_b.rd_data), 128'(0));
        check({tag, "_ready_a"}, 128'(bus_a.ld_ready), 128'(0));
        check({tag, "_ready_b"}, 128'(bus_b.ld_ready), 128'(0));
    endtask

    // Read-response monitor: pops the expected entry whenever a DUT presents rd_valid.
    always @(negedge clk) begin
        logic             v;
        logic [WIDTH-1:0] d;
        exp_t             e;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                v = (i == 0) ? bus_a.rd_valid : bus_b.rd_valid;
                d = (i == 0) ? bus_a.rd_data  : bus_b.rd_data;
                while (q[i].size() > 0 && q[i][0].due < cyc) begin
                    e = q[i].pop_front();
                    check($sformatf("rd_missing_%0d", i), 128'(0), 128'(1));
                end
                if (v) begin
                    if (q[i].size() == 0) begin
                        check($sformatf("rd_spurious_%0d", i), 128'(1), 128'(0));
                    end else begin
                        e = q[i].pop_front();
                        check($sformatf("rd_latency_%0d", i), 128'(cyc), 128'(e.due));
                        if (e.chk) check($sformatf("rd_data_%0d", i), 128'(d), 128'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < int'(WORDS); i++) m_wr[i] = 0;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Short load, last on the fourth word.
        drive(1, 0, '0, 0, 0, 0);
        for (int k = 0; k < 4; k++) drive(0, 1, rnd_word(), k == 3, 0, 0);
        idle(2);

        // Full buffer without ld_last, with concurrent reads of already-written words.
        drive(1, 0, '0, 0, 0, 0);
        for (int k = 0; k < int'(WORDS); k++)
            drive(0, 1, rnd_word(), 0, ($urandom % 2) == 1, (k > 0) ? int'($urandom_range(k - 1)) : 0);
        idle(1);
        drive(0, 0, '0, 0, 1, 0);
        drive(0, 0, '0, 0, 1, WORDS - 1);
        idle(3);

        // Word offered in DONE is dropped and flags overflow.
        drive(0, 1, rnd_word(), 0, 0, 0);
        idle(2);
        drive(0, 0, '0, 0, 1, 0);
        idle(3);
        drive(1, 0, '0, 0, 0, 0);

        // Same-address read during write: old vs bypassed data.
        for (int k = 0; k < 5; k++) drive(0, 1, rnd_word(), 0, 0, 0);
        drive(0, 1, WIDTH'(73'h0AA), 1, 0, 0);
        idle(2);
        drive(1, 0, '0, 0, 0, 0);
        for (int k = 0; k < 5; k++) drive(0, 1, rnd_word(), 0, 0, 0);
        drive(0, 1, WIDTH'(73'h1_2345), 1, 1, 5);
        idle(3);

        // Asynchronous reset mid-load; memory contents survive.
        drive(1, 0, '0, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 1, rnd_word(), 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        q[0].delete();
        q[1].delete();
        m_loading = 0; m_done = 0; m_cnt = 0; m_loaded = 0; m_ovf = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 0, '0, 0, 1, 2);
        idle(3);

        // ld_start beats a same-cycle word; then back-to-back reads every cycle.
        drive(1, 0, '0, 0, 0, 0);
        drive(1, 1, rnd_word(), 0, 0, 0);
        drive(0, 1, rnd_word(), 1, 0, 0);
        for (int k = 0; k < 20; k++) drive(0, 0, '0, 0, 1, (k == 0) ? 0 : int'($urandom_range(WORDS - 1)));
        idle(3);

        // Randomized mix of loads, restarts, overflows and reads.
        for (int k = 0; k < 500; k++)
            drive(($urandom % 50) == 0, ($urandom % 4) != 0, rnd_word(), ($urandom % 40) == 0,
                  ($urandom % 2) == 1, int'($urandom_range(WORDS - 1)));
        idle(5);

        check("drain_a", 128'(q[0].size()), 128'(0));
        check("drain_b", 128'(q[1].size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
